aeg_dispatch: RTL and testbench

Dispatch-side control stage of the personality. It sits directly downstream of the instruction decoder and consumes its decoded outputs (valid, CAEP number, AEG write/read, index) plus the 64-bit dispatch data. It owns the application engine register (AEG) file and returns AEG read data to the host. It launches the kernel on CAEP 00 and drives the `idle`, `stall` and `exception` signals back to dispatch.

---
 rtl/aeg_dispatch.sv | 148 ++++++++++++++
 tb/tb_aeg_dispatch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aeg_dispatch.sv
// -----------------------------------------------------------------------------
// aeg_dispatch
//   Dispatch-side control stage. Owns the AEG register file, answers host AEG
//   reads, launches the kernel on CAEP KRN_CAEP and reports idle/stall and
//   exception status back to dispatch.
//
// Handshake: there is no back-pressure. Every instruction input is a single-
//   cycle pulse sampled on a rising clk edge. Every response (krn_start,
//   cae_ret_data_vld, cae_exception) is a single-cycle pulse registered on the
//   following edge. A response is never withheld: an out-of-range read still
//   returns data 0 together with vld.
//
// Ports
//   clk, i_reset_n      clock, asynchronous active-low reset
//   inst_*              decoded instruction fields from the decoder
//   cae_data            host write data
//   krn_done            kernel completion pulse
//   krn_rslt_*          kernel result write into the AEG file
//   krn_start           kernel launch pulse
//   aeg_flat            all AEGs, AEG n in bits [64n+63:64n]
//   cae_aeg_cnt         constant NUM_AEG
//   cae_ret_data/_vld   AEG read return
//   cae_exception       exception flags (bits 0..3 used)
//   cae_idle/cae_stall  kernel running status
//   dbg_state           current FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module aeg_dispatch #(
   parameter int NUM_AEG  = 16,
   parameter int KRN_CAEP = 0
) (
   input  logic                    clk,
   input  logic                    i_reset_n,
   input  logic                    inst_val,
   input  logic [4:0]              inst_caep,
   input  logic                    inst_aeg_wr,
   input  logic                    inst_aeg_rd,
   input  logic [17:0]             inst_aeg_idx,
   input  logic [63:0]             cae_data,
   input  logic                    krn_done,
   input  logic                    krn_rslt_we,
   input  logic [5:0]              krn_rslt_idx,
   input  logic [63:0]             krn_rslt_data,
   output logic                    krn_start,
   output logic [NUM_AEG*64-1:0]   aeg_flat,
   output logic [17:0]             cae_aeg_cnt,
   output logic [63:0]             cae_ret_data,
   output logic                    cae_ret_data_vld,
   output logic [15:0]             cae_exception,
   output logic                    cae_idle,
   output logic                    cae_stall,
   output logic                    dbg_state
);

   localparam int IW = (NUM_AEG > 1) ? $clog2(NUM_AEG) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [63:0] aeg_q [NUM_AEG];

   logic host_in_range;
   logic krn_in_range;
   logic is_krn_caep;
   logic launch;
   logic host_wr_ok;
   logic krn_wr_ok;

   assign host_in_range = (inst_aeg_idx < 18'(NUM_AEG));
   assign krn_in_range  = ({1'b0, krn_rslt_idx} < 7'(NUM_AEG));
   assign is_krn_caep   = (inst_caep == 5'(KRN_CAEP));
   assign launch        = inst_val && is_krn_caep && (state_q == IDLE);
   // Host writes are only honoured while no kernel is running.
   assign host_wr_ok    = inst_aeg_wr && host_in_range && (state_q == IDLE);
   assign krn_wr_ok     = krn_rslt_we && krn_in_range;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // krn_done while IDLE is ignored, so launch has no competitor in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (launch)   state_d = BUSY;
         BUSY: if (krn_done) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   assign cae_stall   = (state_q == BUSY);
   assign cae_idle    = (state_q == IDLE);
   assign dbg_state   = state_q;
   assign cae_aeg_cnt = 18'(NUM_AEG);

   // ---------------- AEG file ----------------
   // Host write has priority over a kernel result write to the same register.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_AEG; i++) aeg_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_AEG; i++) begin
            if (host_wr_ok && (inst_aeg_idx[IW-1:0] == IW'(i))) begin
               aeg_q[i] <= cae_data;
            end else if (krn_wr_ok && (krn_rslt_idx[IW-1:0] == IW'(i))) begin
               aeg_q[i] <= krn_rslt_data;
            end
         end
      end
   end

   always_comb begin
      aeg_flat = '0;
      for (int i = 0; i < NUM_AEG; i++) aeg_flat[64*i +: 64] = aeg_q[i];
   end

   // ---------------- responses ----------------
   // The read samples aeg_q before any same-edge write lands, so a colliding
   // read returns the old value.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         krn_start        <= 1'b0;
         cae_ret_data     <= '0;
         cae_ret_data_vld <= 1'b0;
         cae_exception    <= '0;
      end else begin
         krn_start        <= launch;
         cae_ret_data_vld <= inst_aeg_rd;
         if (inst_aeg_rd) begin
            cae_ret_data <= host_in_range ? aeg_q[inst_aeg_idx[IW-1:0]] : 64'd0;
         end
         cae_exception     <= '0;
         cae_exception[0]  <= inst_val && !is_krn_caep;
         cae_exception[1]  <= (inst_aeg_rd || inst_aeg_wr) && !host_in_range;
         cae_exception[2]  <= inst_aeg_wr && (state_q == BUSY);
         cae_exception[3]  <= inst_val && is_krn_caep && (state_q == BUSY);
      end
   end

endmodule

// File: tb/tb_aeg_dispatch.sv
// -----------------------------------------------------------------------------
// tb_aeg_dispatch
//   Self-checking bench for aeg_dispatch (NUM_AEG=16, KRN_CAEP=0). A reference
//   model (register array + busy flag) predicts every output; directed
//   scenario tasks and a randomized run compare the DUT against it.
// -----------------------------------------------------------------------------
module tb_aeg_dispatch;

  localparam int NA  = 16;
  localparam int KRN = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        inst_val = 0;
  logic [4:0]  inst_caep = 0;
  logic        inst_aeg_wr = 0;
  logic        inst_aeg_rd = 0;
  logic [17:0] inst_aeg_idx = 0;
  logic [63:0] cae_data = 0;
  logic        krn_done = 0;
  logic        krn_rslt_we = 0;
  logic [5:0]  krn_rslt_idx = 0;
  logic [63:0] krn_rslt_data = 0;

  logic            krn_start;
  logic [NA*64-1:0] aeg_flat;
  logic [17:0]     cae_aeg_cnt;
  logic [63:0]     cae_ret_data;
  logic            cae_ret_data_vld;
  logic [15:0]     cae_exception;
  logic            cae_idle;
  logic            cae_stall;
  logic            dbg_state;

  aeg_dispatch #(.NUM_AEG(NA), .KRN_CAEP(KRN)) dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .inst_val(inst_val), .inst_caep(inst_caep),
    .inst_aeg_wr(inst_aeg_wr), .inst_aeg_rd(inst_aeg_rd),
    .inst_aeg_idx(inst_aeg_idx), .cae_data(cae_data),
    .krn_done(krn_done), .krn_rslt_we(krn_rslt_we),
    .krn_rslt_idx(krn_rslt_idx), .krn_rslt_data(krn_rslt_data),
    .krn_start(krn_start), .aeg_flat(aeg_flat), .cae_aeg_cnt(cae_aeg_cnt),
    .cae_ret_data(cae_ret_data), .cae_ret_data_vld(cae_ret_data_vld),
    .cae_exception(cae_exception), .cae_idle(cae_idle),
    .cae_stall(cae_stall), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [63:0] mdl_mem [NA];
  logic        mdl_busy;
  logic [63:0] exp_ret;
  logic        exp_vld;
  logic [15:0] exp_exc;
  logic        exp_start;

  function automatic logic [NA*64-1:0] model_flat();
    logic [NA*64-1:0] f;
    for (int i = 0; i < NA; i++) f[64*i +: 64] = mdl_mem[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) mdl_mem[i] = '0;
    mdl_busy  = 0;
    exp_ret   = 0;
    exp_vld   = 0;
    exp_exc   = 0;
    exp_start = 0;
  endtask

  // ---------------- driver ----------------
  task automatic clear_inputs();
    inst_val = 0; inst_caep = 0; inst_aeg_wr = 0; inst_aeg_rd = 0;
    inst_aeg_idx = 0; cae_data = 0; krn_done = 0;
    krn_rslt_we = 0; krn_rslt_idx = 0; krn_rslt_data = 0;
  endtask

  // Predict the response to the current inputs, clock once, then release
  // the pulses. Outputs are sampled 1 ns after the edge by the callers.
  task automatic tick();
    logic [15:0] e;
    logic h_ok, k_ok, is_k;
    h_ok = (inst_aeg_idx < NA);
    k_ok = (krn_rslt_idx < NA);
    is_k = (inst_caep == KRN);
    e = 0;
    if (inst_val && !is_k)                     e[0] = 1;
    if ((inst_aeg_rd || inst_aeg_wr) && !h_ok) e[1] = 1;
    if (inst_aeg_wr && mdl_busy)               e[2] = 1;
    if (inst_val && is_k && mdl_busy)          e[3] = 1;
    exp_exc   = e;
    exp_vld   = inst_aeg_rd;
    if (inst_aeg_rd) exp_ret = h_ok ? mdl_mem[inst_aeg_idx[3:0]] : 64'd0;
    exp_start = inst_val && is_k && !mdl_busy;
    if (krn_rslt_we && k_ok) mdl_mem[krn_rslt_idx[3:0]] = krn_rslt_data;
    if (inst_aeg_wr && h_ok && !mdl_busy) mdl_mem[inst_aeg_idx[3:0]] = cae_data;
    if (!mdl_busy && exp_start) mdl_busy = 1;
    else if (mdl_busy && krn_done) mdl_busy = 0;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cae_idle !== 1'b1 || cae_stall !== 1'b0 || krn_start !== 1'b0 ||
        cae_ret_data_vld !== 1'b0 || cae_exception !== 16'h0 || cae_ret_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: idle=%b stall=%b start=%b vld=%b exc=%h ret=%h, required 1 0 0 0 0000 0",
               cae_idle, cae_stall, krn_start, cae_ret_data_vld, cae_exception, cae_ret_data);
    end
    checks++;
    if (aeg_flat !== '0) begin
      errors++; $display("FAIL reset_aeg: aeg_flat not zero");
    end
    checks++;
    if (cae_aeg_cnt !== 18'd16) begin
      errors++; $display("FAIL aeg_cnt: got %0d required 16", cae_aeg_cnt);
    end
    i_reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    inst_aeg_wr = 1; inst_aeg_idx = 3; cae_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    checks++;
    if (aeg_flat[255:192] !== 64'hDEADBEEF00000001) begin
      errors++; $display("FAIL wr_aeg3: got %h required deadbeef00000001", aeg_flat[255:192]);
    end
    inst_aeg_rd = 1; inst_aeg_idx = 3;
    tick();
    checks++;
    if (cae_ret_data_vld !== 1'b1 || cae_ret_data !== 64'hDEADBEEF00000001 || cae_exception !== 16'h0) begin
      errors++;
      $display("FAIL rd_aeg3: vld=%b data=%h exc=%h required 1 deadbeef00000001 0000",
               cae_ret_data_vld, cae_ret_data, cae_exception);
    end
    tick();
    checks++;
    if (cae_ret_data_vld !== 1'b0) begin
      errors++; $display("FAIL rd_vld_pulse: vld=%b required 0", cae_ret_data_vld);
    end
  endtask

  task automatic test_oob_read();
    inst_aeg_rd = 1; inst_aeg_idx = 16;
    tick();
    checks++;
    if (cae_ret_data_vld !== 1'b1 || cae_ret_data !== 64'h0 || cae_exception !== 16'h0002) begin
      errors++;
      $display("FAIL oob_read: vld=%b data=%h exc=%h required 1 0 0002",
               cae_ret_data_vld, cae_ret_data, cae_exception);
    end
    tick();
    checks++;
    if (cae_exception !== 16'h0 || cae_ret_data_vld !== 1'b0) begin
      errors++; $display("FAIL oob_pulse: exc=%h vld=%b required 0000 0", cae_exception, cae_ret_data_vld);
    end
  endtask

  task automatic test_kernel();
    logic [63:0] aeg1_before;
    aeg1_before = aeg_flat[127:64];
    inst_val = 1; inst_caep = 0;
    tick();
    checks++;
    if (krn_start !== 1'b1 || cae_stall !== 1'b1 || cae_idle !== 1'b0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL launch: start=%b stall=%b idle=%b state=%b required 1 1 0 1",
               krn_start, cae_stall, cae_idle, dbg_state);
    end
    inst_aeg_wr = 1; inst_aeg_idx = 1; cae_data = 64'h5555;
    tick();
    checks++;
    if (krn_start !== 1'b0 || cae_exception !== 16'h0004 || aeg_flat[127:64] !== aeg1_before) begin
      errors++;
      $display("FAIL busy_write: start=%b exc=%h aeg1=%h required 0 0004 %h",
               krn_start, cae_exception, aeg_flat[127:64], aeg1_before);
    end
    inst_val = 1; inst_caep = 0;
    tick();
    checks++;
    if (cae_exception !== 16'h0008 || krn_start !== 1'b0 || cae_stall !== 1'b1) begin
      errors++;
      $display("FAIL busy_caep: exc=%h start=%b stall=%b required 0008 0 1",
               cae_exception, krn_start, cae_stall);
    end
    krn_done = 1;
    tick();
    checks++;
    if (cae_stall !== 1'b0 || cae_idle !== 1'b1) begin
      errors++; $display("FAIL done: stall=%b idle=%b required 0 1", cae_stall, cae_idle);
    end
    inst_aeg_wr = 1; inst_aeg_idx = 1; cae_data = 64'h7777;
    tick();
    checks++;
    if (aeg_flat[127:64] !== 64'h7777 || cae_exception !== 16'h0) begin
      errors++; $display("FAIL post_done_write: aeg1=%h exc=%h required 7777 0000", aeg_flat[127:64], cae_exception);
    end
  endtask

  task automatic test_back_to_back();
    // launch, done on the very next cycle, then relaunch immediately
    inst_val = 1; inst_caep = 0;
    tick();
    krn_done = 1;
    tick();
    inst_val = 1; inst_caep = 0;
    tick();
    checks++;
    if (krn_start !== 1'b1 || cae_stall !== 1'b1 || cae_exception !== 16'h0) begin
      errors++;
      $display("FAIL relaunch: start=%b stall=%b exc=%h required 1 1 0000", krn_start, cae_stall, cae_exception);
    end
    krn_done = 1;
    tick();
  endtask

  task automatic test_bad_caep();
    inst_val = 1; inst_caep = 5;
    tick();
    checks++;
    if (cae_exception !== 16'h0001 || krn_start !== 1'b0 || cae_stall !== 1'b0) begin
      errors++;
      $display("FAIL bad_caep: exc=%h start=%b stall=%b required 0001 0 0", cae_exception, krn_start, cae_stall);
    end
  endtask

  task automatic test_collision();
    inst_aeg_wr = 1; inst_aeg_idx = 2; cae_data = 64'h11;
    krn_rslt_we = 1; krn_rslt_idx = 2; krn_rslt_data = 64'h22;
    tick();
    checks++;
    if (aeg_flat[191:128] !== 64'h11) begin
      errors++; $display("FAIL host_wins: aeg2=%h required 11", aeg_flat[191:128]);
    end
    // read and write of the same index in one cycle returns the old value
    inst_aeg_rd = 1; inst_aeg_wr = 1; inst_aeg_idx = 2; cae_data = 64'h33;
    tick();
    checks++;
    if (cae_ret_data !== 64'h11 || aeg_flat[191:128] !== 64'h33) begin
      errors++; $display("FAIL rd_wr_same: ret=%h aeg2=%h required 11 33", cae_ret_data, aeg_flat[191:128]);
    end
    inst_val = 1; inst_caep = 0;
    tick();
    krn_rslt_we = 1; krn_rslt_idx = 4; krn_rslt_data = 64'hABCD_0123;
    tick();
    inst_aeg_rd = 1; inst_aeg_idx = 4;
    tick();
    checks++;
    if (cae_ret_data_vld !== 1'b1 || cae_ret_data !== 64'hABCD_0123) begin
      errors++; $display("FAIL krn_busy_write: vld=%b ret=%h required 1 abcd0123", cae_ret_data_vld, cae_ret_data);
    end
    krn_done = 1;
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      inst_val    = ($urandom_range(0, 9) < 2);
      inst_caep   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      inst_aeg_wr = ($urandom_range(0, 3) == 0);
      inst_aeg_rd = ($urandom_range(0, 3) == 0);
      inst_aeg_idx = ($urandom_range(0, 9) == 0) ? 18'($urandom_range(16, 262143))
                                                 : 18'($urandom_range(0, 17));
      cae_data     = {$urandom, $urandom};
      krn_done     = ($urandom_range(0, 5) == 0);
      krn_rslt_we  = ($urandom_range(0, 3) == 0);
      krn_rslt_idx = 6'($urandom_range(0, 20));
      krn_rslt_data = {$urandom, $urandom};
      tick();
      checks++;
      if (krn_start !== exp_start || cae_ret_data_vld !== exp_vld ||
          cae_exception !== exp_exc || cae_stall !== mdl_busy ||
          cae_idle !== !mdl_busy || dbg_state !== mdl_busy ||
          (exp_vld && cae_ret_data !== exp_ret) || aeg_flat !== model_flat()) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: start=%b/%b vld=%b/%b exc=%h/%h stall=%b/%b ret=%h/%h flat_ok=%b",
                   n, krn_start, exp_start, cae_ret_data_vld, exp_vld, cae_exception, exp_exc,
                   cae_stall, mdl_busy, cae_ret_data, exp_ret, aeg_flat === model_flat());
      end
    end
  endtask

  task automatic test_reset_busy();
    for (int i = 0; i < 4; i++) begin
      inst_aeg_wr = 1; inst_aeg_idx = 18'(i); cae_data = 64'h100 + 64'(i);
      if (mdl_busy) krn_done = 1;
      tick();
    end
    if (mdl_busy) begin krn_done = 1; tick(); end
    inst_aeg_wr = 1; inst_aeg_idx = 5; cae_data = 64'hFACE;
    tick();
    inst_val = 1; inst_caep = 0;
    tick();
    checks++;
    if (cae_stall !== 1'b1 || aeg_flat === '0) begin
      errors++; $display("FAIL pre_reset_busy: stall=%b required 1 with AEGs populated", cae_stall);
    end
    #2;
    i_reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (cae_stall !== 1'b0 || cae_idle !== 1'b1 || aeg_flat !== '0 || krn_start !== 1'b0 ||
        cae_exception !== 16'h0 || cae_ret_data_vld !== 1'b0 || cae_ret_data !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: stall=%b idle=%b start=%b exc=%h vld=%b flat_zero=%b",
               cae_stall, cae_idle, krn_start, cae_exception, cae_ret_data_vld, aeg_flat === '0);
    end
    @(posedge clk); #1;
    i_reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (krn_start !== 1'b0 || cae_stall !== 1'b0) begin
        errors++; $display("FAIL post_reset[%0d]: start=%b stall=%b required 0 0", i, krn_start, cae_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_oob_read();
    test_kernel();
    test_back_to_back();
    test_bad_caep();
    test_collision();
    test_random();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
